mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Sequences and shares the single 16-bit asynchronous memory bus between two requesters: the instruction-fetch port (read-only) and the data port (read/write).
- Drives address, request, rw and write data to the memory, honours its wait_ line, captures read data, and returns a one-cycle ack to the granted requester.
- Sits between the CPU core and the Memory module, and is the only driver of the memory bus.

Parameters:
ADDR_W, 16, width of address ports and mem_addr
DATA_W, 16, width of all data ports
MAX_D_BURST, 4, maximum consecutive data-port grants while fetch is pending before fetch is forced (range 1..15)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
if_req  in  1  fetch request; level, held until if_ack
if_addr  in  ADDR_W  fetch address
if_rdata  out  DATA_W  fetched word; valid with if_ack, held until the next if_ack
if_ack  out  1  one-cycle completion pulse for fetch
d_req  in  1  data request; level, held until d_ack
d_we  in  1  1 = write, 0 = read
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_rdata  out  DATA_W  read word; valid with d_ack, held until the next d_ack
d_ack  out  1  one-cycle completion pulse for data
mem_addr  out  ADDR_W  memory address bus (addrs_bus)
mem_request  out  1  memory request strobe
mem_rw  out  1  1 = read, 0 = write; idles at 1
mem_wdata  out  DATA_W  memory write data bus
mem_rdata  in  DATA_W  memory read data bus
mem_wait  in  1  memory busy; access extends while high
grant_d  out  1  1 while the current/last transaction belongs to the data port

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - Outputs: mem_rw=1, mem_request=0, mem_addr=0, mem_wdata=0, if_ack=d_ack=0, if_rdata=d_rdata=0, grant_d=0.
  - Internal: burst counter=0, state=IDLE.
  - Reset mid-write must force mem_rw=1 at once, so no spurious write occurs after reset.
- The memory writes level-sensitively whenever rw=0. Therefore:
  - mem_rw is 0 only in ACCESS of a write.
  - mem_addr and mem_wdata are stable one full cycle before mem_rw falls and one full cycle after it rises.
- FSM states: IDLE, SETUP, ACCESS, RECOVER, DONE.
- IDLE:
  - Sample requests and arbitrate.
  - Latch the winner's addr, we and wdata into internal registers.
  - Go to SETUP. With no request, stay in IDLE.
- SETUP:
  - mem_addr = latched address; mem_wdata = latched data (writes); mem_request=1; mem_rw=1.
  - Go to ACCESS.
- ACCESS:
  - mem_request=1; mem_rw=0 if write, else 1.
  - Stay while mem_wait=1; minimum one cycle.
  - When mem_wait=0: a read captures mem_rdata into the winner's rdata register and goes to DONE; a write goes to RECOVER.
- RECOVER (write only):
  - mem_rw=1, address and data held, mem_request=1.
  - Go to DONE.
- DONE:
  - mem_request=0; pulse the winner's ack for exactly one cycle.
  - Go to IDLE.
- Latency from the IDLE sampling edge to ack high: read 3 cycles, write 4 cycles, plus one per mem_wait-high cycle.
- A requester deasserts req on the edge where it sees ack. A req still high in the IDLE after DONE is a new transaction.
- Request inputs are ignored outside IDLE. Changes to the requester's addr/wdata after the IDLE latch do not affect the transaction.
- Arbitration (IDLE only):
  - Data has priority over fetch.
  - The burst counter increments on each data grant made while if_req=1, and clears on any fetch grant or whenever if_req=0.
  - If the counter equals MAX_D_BURST and both requesters are pending, fetch wins.
  - A single requester always wins.
  - grant_d updates on each grant and holds otherwise.
- Data reads and writes share one FSM path; the fetch port never writes.
- mem_addr is driven at full ADDR_W width; address decoding is the memory's responsibility.

Decomposition:
- Shared package mem_ctrl_pkg:
  - state enum {IDLE, SETUP, ACCESS, RECOVER, DONE}
  - RW_READ=1'b1, RW_WRITE=1'b0
  - port ID constants PORT_IF=0, PORT_D=1
- One sub-module, mem_arb_pick: combinational priority choice plus the registered burst counter. Inputs: if_req, d_req, take (IDLE grant strobe). Outputs: pick_d.
- FSM, latches and bus drivers live in mem_bus_arbiter.

Test Plan:
- Preload mem[4]=16'hABCD; if_req with if_addr=4, mem_wait=0 -> if_ack high 3 cycles later, if_rdata=16'hABCD, mem_rw never 0.
- d_req, d_we=1, d_addr=8, d_wdata=16'h1234 -> mem_rw=0 for exactly one cycle, mem_addr=8 from SETUP through RECOVER, d_ack 4 cycles later; a following data read of addr 8 returns 16'h1234.
- Read with mem_wait held high 3 ACCESS cycles -> ack at cycle 6; mem_request high throughout SETUP..ACCESS.
- if_req and d_req held continuously, MAX_D_BURST=4 -> grant order D,D,D,D,IF,D,D,D,D,IF.
- Assert reset during ACCESS of a write -> mem_rw=1 and mem_request=0 immediately (same time step), no ack; after release, FSM is IDLE and the memory location is unchanged.
- Change d_addr from 8 to 9 during ACCESS -> transaction completes on address 8.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory bus arbiter.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    RECOVER,
    DONE
  } state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  // Wide enough for the largest allowed data burst (15)
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester ports and memory bus of the arbiter, bundled for connection.
interface mem_bus_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_request;
  logic              mem_rw;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_wait;

  logic              grant_d;

  // Arbiter side
  modport master (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_wait,
    output if_rdata, if_ack, d_rdata, d_ack,
           mem_addr, mem_request, mem_rw, mem_wdata, grant_d
  );

  // Requesters and memory side
  modport slave (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_wait,
    input  if_rdata, if_ack, d_rdata, d_ack,
           mem_addr, mem_request, mem_rw, mem_wdata, grant_d
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Data-priority arbitration with a burst limit that forces a pending fetch through.
module mem_arb_pick
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned MAX_D_BURST = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic if_req,
  input  logic d_req,
  input  logic take,
  output logic pick_d
);

  logic [CNT_W-1:0] burst_cnt;

  assign pick_d = d_req && !(if_req && (burst_cnt == CNT_W'(MAX_D_BURST)));

  // Counts data grants made while fetch is waiting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      burst_cnt <= '0;
    end else if (!if_req) begin
      burst_cnt <= '0;
    end else if (take) begin
      burst_cnt <= pick_d ? burst_cnt + CNT_W'(1) : '0;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Sequences the shared asynchronous memory bus for the fetch and data ports.
module mem_bus_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned MAX_D_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  mem_bus_arbiter_if.master bus
);

  state_t state;
  logic   lat_we;
  logic   take;
  logic   pick_d;

  assign take = (state == IDLE) && (bus.if_req || bus.d_req);

  mem_arb_pick #(
    .MAX_D_BURST (MAX_D_BURST)
  ) u_pick (
    .clk    (clk),
    .reset  (reset),
    .if_req (bus.if_req),
    .d_req  (bus.d_req),
    .take   (take),
    .pick_d (pick_d)
  );

  // mem_addr/mem_wdata double as the transaction latches, so they stay
  // stable across the whole write strobe and the recovery cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      lat_we          <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_wdata   <= '0;
      bus.mem_request <= 1'b0;
      bus.mem_rw      <= RW_READ;
      bus.if_rdata    <= '0;
      bus.d_rdata     <= '0;
      bus.if_ack      <= 1'b0;
      bus.d_ack       <= 1'b0;
      bus.grant_d     <= 1'b0;
    end else begin
      bus.if_ack <= 1'b0;
      bus.d_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (take) begin
            bus.grant_d     <= pick_d ? PORT_D : PORT_IF;
            lat_we          <= pick_d && bus.d_we;
            bus.mem_addr    <= ADDR_W'(pick_d ? bus.d_addr : bus.if_addr);
            if (pick_d) begin
              bus.mem_wdata <= DATA_W'(bus.d_wdata);
            end
            bus.mem_request <= 1'b1;
            bus.mem_rw      <= RW_READ;
            state           <= SETUP;
          end
        end
        SETUP: begin
          bus.mem_rw <= lat_we ? RW_WRITE : RW_READ;
          state      <= ACCESS;
        end
        ACCESS: begin
          if (!bus.mem_wait) begin
            if (lat_we) begin
              bus.mem_rw <= RW_READ;
              state      <= RECOVER;
            end else begin
              if (bus.grant_d) begin
                bus.d_rdata  <= DATA_W'(bus.mem_rdata);
                bus.d_ack    <= 1'b1;
              end else begin
                bus.if_rdata <= DATA_W'(bus.mem_rdata);
                bus.if_ack   <= 1'b1;
              end
              bus.mem_request <= 1'b0;
              state           <= DONE;
            end
          end
        end
        RECOVER: begin
          bus.mem_request <= 1'b0;
          bus.d_ack       <= bus.grant_d;
          bus.if_ack      <= !bus.grant_d;
          state           <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
